// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : wb_arbiter_pkg                                                   |
// | Purpose : Core-wide RISC-V defines shared by the writeback path: machine   |
// |           word width, architectural register count and the writeback       |
// |           entry type buffered between the LSU and the register file.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package wb_arbiter_pkg;

  localparam int RISCV_WORD_WIDTH = 32;
  localparam int GP_REG_COUNT     = 32;
  localparam int GP_REG_AW        = $clog2(GP_REG_COUNT);

  // One pending register file write: destination register plus its data.
  typedef struct packed {
    logic [GP_REG_AW-1:0]        rd;
    logic [RISCV_WORD_WIDTH-1:0] data;
  } wb_entry_t;

endpackage : wb_arbiter_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : wb_fifo                                                          |
// | Purpose : Generic synchronous FIFO. The head entry is always visible on    |
// |           dout (first-word fall-through), so the consumer can inspect it   |
// |           before deciding to pop.                                          |
// | Ports   : clk, rst_n (async, active-low)                                   |
// |           push/din  - write din when not full                              |
// |           pop/dout  - dout is the head; pop consumes it when not empty     |
// |           full/empty - occupancy flags                                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : wb_arbiter                                                       |
// | Purpose : Merges single-cycle ALU results and variable-latency LSU load    |
// |           responses onto the single register file write port. Load data   |
// |           is buffered in a small FIFO; a scoreboard of in-flight load      |
// |           destinations drives the decode hazard signal; a starvation guard |
// |           stalls the ALU when a buffered load has waited too long.         |
// | Ports   : clk, rst_n (async, active-low)                                   |
// |           alu_valid_i/alu_rd_i/alu_data_i  - ALU result, alu_stall_o back  |
// |           load_issue_i/load_issue_rd_i     - load issue (sets pending)     |
// |           lsu_valid_i/lsu_rd_i/lsu_data_i  - load response, lsu_ready_o    |
// |           rs1/rs2/rd_addr_i, hazard_o      - decode hazard query           |
// |           write_en_o/addr_o/data_o         - register file write port      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = RISCV_WORD_WIDTH,
  parameter int REG_COUNT    = GP_REG_COUNT,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3,
  localparam int AW          = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // ALU result
  input  logic                  alu_valid_i,
  input  logic [AW-1:0]         alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  output logic                  alu_stall_o,
  // Load issue
  input  logic                  load_issue_i,
  input  logic [AW-1:0]         load_issue_rd_i,
  // LSU response
  input  logic                  lsu_valid_i,
  input  logic [AW-1:0]         lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  output logic                  lsu_ready_o,
  // Decode hazard query
  input  logic [AW-1:0]         rs1_addr_i,
  input  logic [AW-1:0]         rs2_addr_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic                  hazard_o,
  // Register file write port
  output logic                  write_en_o,
  output logic [AW-1:0]         write_addr_o,
  output logic [DATA_WIDTH-1:0] write_data_o
);

  localparam int EW = AW + DATA_WIDTH;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  // ---------------------------------------------------------------------------
  // Load response buffer
  // ---------------------------------------------------------------------------
  logic [EW-1:0]         w_push_entry;
  logic [EW-1:0]         w_head;
  logic [AW-1:0]         w_head_rd;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;

  assign w_push_entry = {lsu_rd_i, lsu_data_i};
  assign w_head_rd    = w_head[EW-1:DATA_WIDTH];
  assign w_head_data  = w_head[DATA_WIDTH-1:0];
  assign lsu_ready_o  = !w_fifo_full;
  assign w_push       = lsu_valid_i && lsu_ready_o;

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_push_entry),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Arbitration: the ALU always wins; buffered loads drain on idle ALU cycles.
  // x0 destinations are never written, but a popped x0 entry is still consumed.
  // ---------------------------------------------------------------------------
  logic w_wr_en;

  always_comb begin
    w_pop        = 1'b0;
    w_wr_en      = 1'b0;
    write_addr_o = alu_rd_i;
    write_data_o = alu_data_i;
    if (alu_valid_i) begin
      w_wr_en = (alu_rd_i != '0);
    end else if (!w_fifo_empty) begin
      w_pop        = 1'b1;
      write_addr_o = w_head_rd;
      write_data_o = w_head_data;
      w_wr_en      = (w_head_rd != '0);
    end
  end

  // The reset term keeps the register file safe while an ALU result is still
  // being presented during reset.
  assign write_en_o = w_wr_en && rst_n;

  // ---------------------------------------------------------------------------
  // Scoreboard of destinations with a load in flight
  // ---------------------------------------------------------------------------
  logic [REG_COUNT-1:0] r_pending;
  logic [REG_COUNT-1:0] w_pending_nxt;

  // Clear is applied before set so a same-cycle reissue of the register being
  // written back keeps it pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) begin
      w_pending_nxt[w_head_rd] = 1'b0;
    end
    if (load_issue_i && (load_issue_rd_i != '0)) begin
      w_pending_nxt[load_issue_rd_i] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign hazard_o = r_pending[rs1_addr_i] | r_pending[rs2_addr_i] | r_pending[rd_addr_i];

  // ---------------------------------------------------------------------------
  // Starvation guard: count consecutive cycles a buffered load is blocked.
  // ---------------------------------------------------------------------------
  logic [WW-1:0] r_wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_fifo_empty || w_pop) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WW'(STARVE_LIMIT)) begin
      r_wait_cnt <= r_wait_cnt + WW'(1);
    end
  end

  assign alu_stall_o = (r_wait_cnt == WW'(STARVE_LIMIT));

  // ---------------------------------------------------------------------------
  // Protocol checks (upstream misbehaviour; the datapath still proceeds)
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_alu_while_stalled : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(alu_valid_i && alu_stall_o)
  ) else $error("wb_arbiter: ALU result presented while stalled");

  a_alu_to_pending : assert property (
    @(posedge clk) disable iff (!rst_n)
    (alu_valid_i && (alu_rd_i != '0)) |-> !r_pending[alu_rd_i]
  ) else $error("wb_arbiter: ALU write to a register with a load in flight");

  // x0 loads are never tracked, so their responses are exempt.
  a_lsu_not_pending : assert property (
    @(posedge clk) disable iff (!rst_n)
    (lsu_valid_i && lsu_ready_o && (lsu_rd_i != '0)) |-> r_pending[lsu_rd_i]
  ) else $error("wb_arbiter: load response for a register with no load in flight");
`endif

endmodule : wb_arbiter
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and load scoreboard for the BURV core; it is the initiator side of the register file write port. It merges single-cycle ALU results and out-of-order-latency LSU load responses onto the one register file write port. It buffers load data in a small FIFO and tracks which destination registers have loads in flight, so decode can raise a RAW/WAW hazard. It sits between execute/LSU and the register file.

## Interface
- `DATA_WIDTH`, default `RISCV_WORD_WIDTH`: width of the writeback data.
- `REG_COUNT`, default `GP_REG_COUNT`: number of architectural registers. `AW = $clog2(REG_COUNT)`.
- `FIFO_DEPTH`, default 2: depth of the LSU response buffer. Power of two, ≥ 2.
- `STARVE_LIMIT`, default 3: number of cycles a buffered load may be blocked by the ALU before the ALU is stalled.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `alu_valid_i` in 1: ALU result valid this cycle.
- `alu_rd_i` in AW: ALU destination register.
- `alu_data_i` in DATA_WIDTH: ALU result.
- `alu_stall_o` out 1: ALU must not present a result next cycle.
- `load_issue_i` in 1: a load is issued this cycle.
- `load_issue_rd_i` in AW: destination register of the issued load.
- `lsu_valid_i` in 1: load response valid.
- `lsu_rd_i` in AW: load response destination register.
- `lsu_data_i` in DATA_WIDTH: load response data.
- `lsu_ready_o` out 1: FIFO can accept a load response.
- `rs1_addr_i`, `rs2_addr_i`, `rd_addr_i` in AW each: register addresses of the instruction in decode.
- `hazard_o` out 1: one of the decode registers has a pending load.
- `write_en_o` out 1, `write_addr_o` out AW, `write_data_o` out DATA_WIDTH: register file write port.

## Operation
- **Scoreboard.** `pending[REG_COUNT]` is a register of bits.
  - `load_issue_i` sets `pending[load_issue_rd_i]`, except for x0.
  - A write of a FIFO entry to the register file clears `pending[entry.rd]`.
  - If set and clear hit the same bit in the same cycle, set wins.
- **Hazard.** `hazard_o = pending[rs1] | pending[rs2] | pending[rd]`. It is combinational from registered state; x0 is never pending.
- **FIFO push.** A push happens on `lsu_valid_i && lsu_ready_o` and stores `{rd, data}`. `lsu_ready_o = !full`.
- **Arbitration**, combinational:
  - `alu_valid_i` high: the ALU wins. `write_addr_o`/`write_data_o` come from the ALU and there is no pop.
  - Otherwise, if the FIFO is non-empty: pop the head and drive it onto the port.
  - Otherwise: `write_en_o = 0`.
- **x0 suppression.** A destination of x0 forces `write_en_o = 0`. A popped x0 entry is still consumed.
- **Starvation guard.** `wait_cnt` increments on each cycle the FIFO is non-empty with no pop, saturating at `STARVE_LIMIT`. It resets to 0 on a pop or when the FIFO is empty. `alu_stall_o = (wait_cnt == STARVE_LIMIT)`.
- **Protocol errors** (flagged by assertion; the ALU still wins):
  - `alu_valid_i` while `alu_stall_o` is high.
  - An ALU write to a register that is pending.
- `lsu_valid_i` for a register that is not pending is a protocol error, flagged by assertion. The data is still written.

## Timing
- Reset values: FIFO empty, `pending = 0`, `wait_cnt = 0`. Consequently `lsu_ready_o = 1`, `hazard_o = 0`, `alu_stall_o = 0`.
- `write_en_o` is forced to 0 while `rst_n` is low.
- Reset mid-operation discards buffered loads and clears the scoreboard.
- ALU result to write port: 0 cycles (combinational).
- LSU response to write port: ≥ 1 cycle, because every response goes through the FIFO (no bypass).
- `pending` clears on the edge that performs the register file write. `hazard_o` drops the following cycle.
- Load issue sets `pending` on the issuing edge. `hazard_o` rises the next cycle.
- Full FIFO: `lsu_ready_o = 0` from the cycle after the filling push.
  - A pop and a push in the same cycle when full is not allowed, because ready is 0.
  - A simultaneous pop and push when not full leaves the count unchanged.
- Pointers wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits.
- `alu_stall_o` rises after `STARVE_LIMIT` consecutive blocked cycles. It falls in the cycle after the pop.

## Structure
- Add `wb_entry_t` (`rd`, `data`) to `riscv_defines.sv` alongside `RISCV_WORD_WIDTH` and `GP_REG_COUNT`.
- Sub-module `wb_fifo`: a generic synchronous FIFO with `push`/`pop`/`full`/`empty` and an asynchronous active-low reset.
- The scoreboard, arbitration and starvation counter stay in `wb_arbiter`.

## Test plan
- **Reset**: assert `rst_n = 0` with `alu_valid_i = 1`. Required: `write_en_o = 0`, `lsu_ready_o = 1`, `hazard_o = 0`.
- **Load round trip**: issue a load to x5; with `rs1 = 5`, `hazard_o = 1` next cycle. LSU returns x5 = 0xDEADBEEF with no ALU traffic. Required: a write one cycle later, then `hazard_o = 0`.
- **Arbitration**: ALU writes x3 = 7 on the same cycle an x4 response is buffered. Required: x3 is written first, x4 on the next free cycle.
- **Starvation**: FIFO holds x6 while `alu_valid_i` is high continuously. Required: `alu_stall_o = 1` after 3 cycles; once ALU valid drops, x6 is written and `alu_stall_o` deasserts.
- **Full/x0**: push 2 responses while the ALU blocks. Required: `lsu_ready_o = 0`. An x0 response is consumed with `write_en_o = 0`, and x0 never raises `hazard_o`.
- **Simultaneous set/clear**: x7 writeback and a new x7 load issue in the same cycle. Required: `pending[7]` stays 1.
